// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the CPU memory stage and a word-wide,
// one-cycle-latency data RAM. Sub-word stores use read-modify-write because
// the RAM only has a full-word write enable. Sub-word loads are lane-extracted
// and sign/zero-extended. Misaligned or illegal-size requests are rejected
// without any RAM access.
module riscv_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_misaligned,
    output logic [ADDR_WIDTH-1:0] memAdr,
    output logic [DATA_WIDTH-1:0] memwrData,
    output logic                  memWE,
    input  logic [DATA_WIDTH-1:0] memrdData
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_uns;
    logic [DATA_WIDTH-1:0] r_merge;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_mis;
    logic                  w_accept;
    logic                  w_fault;

    // Pick the addressed byte/half out of a RAM word and extend it to 32 bits.
    function automatic logic [DATA_WIDTH-1:0] f_extract(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            lane,
        input logic [1:0]            size,
        input logic                  uns
    );
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   res = {{24{b[7] & ~uns}}, b};
            2'b01:   res = {{16{h[15] & ~uns}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed byte/half of a RAM word, keeping other lanes intact.
    function automatic logic [DATA_WIDTH-1:0] f_merge(
        input logic [DATA_WIDTH-1:0] word,
        input logic [DATA_WIDTH-1:0] wd,
        input logic [1:0]            lane,
        input logic [1:0]            size
    );
        logic [DATA_WIDTH-1:0] res;
        res = word;
        if (size == 2'b00) begin
            res[{lane, 3'b000} +: 8] = wd[7:0];
        end else begin
            res[{lane[1], 4'b0000} +: 16] = wd[15:0];
        end
        return res;
    endfunction

    assign w_accept = req_valid && (r_state == S_IDLE);
    assign w_fault  = (req_size == 2'b11)
                   || ((req_size == 2'b01) && req_addr[0])
                   || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state sequencing and state-decoded outputs.
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        memWE     = 1'b0;
        memwrData = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    if (w_fault) begin
                        w_next = S_DONE;
                    end else if (req_we && (req_size == 2'b10)) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_RD:   w_next = S_CAP;
            S_CAP:  w_next = r_we ? S_WR : S_DONE;
            S_WR: begin
                memWE     = 1'b1;
                memwrData = (r_size == 2'b10) ? r_wdata : r_merge;
                w_next    = S_DONE;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request latches, load capture / store merge, and registered response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_merge <= '0;
            r_rdata <= '0;
            r_mis   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_rdata <= '0;
                        r_mis   <= w_fault;
                    end
                end
                S_CAP: begin
                    if (r_we) begin
                        r_merge <= f_merge(memrdData, r_wdata, r_addr[1:0], r_size);
                    end else begin
                        r_rdata <= f_extract(memrdData, r_addr[1:0], r_size, r_uns);
                    end
                end
                S_DONE: begin
                    r_rdata <= '0;
                    r_mis   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign rsp_rdata      = r_rdata;
    assign rsp_misaligned = r_mis;
    assign memAdr         = {r_addr[ADDR_WIDTH-1:2], 2'b00};

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: a word-wide one-cycle-latency RAM, a reference memory
// model computing expected load data / merged store words from plain shifts and
// masks, a per-cycle compare process, and directed transactions.
module tb_riscv_lsu;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic [31:0] memAdr;
    logic [31:0] memwrData;
    logic        memWE;
    logic [31:0] memrdData;

    riscv_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misaligned(rsp_misaligned), .memAdr(memAdr), .memwrData(memwrData),
        .memWE(memWE), .memrdData(memrdData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data RAM: word-wide, read data registered one edge after the address.
    bit [31:0] ram [0:4095];
    always @(posedge clk) begin
        memrdData <= ram[memAdr[13:2]];
        if (memWE) ram[memAdr[13:2]] <= memwrData;
    end

    int n_cmp = 0;
    int n_err = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endfunction

    // Reference memory contents as the CPU should see them.
    bit [31:0] model_mem [bit [31:0]];

    function automatic bit [31:0] model_rd(input bit [31:0] a);
        bit [31:0] k;
        k = {a[31:2], 2'b00};
        return model_mem.exists(k) ? model_mem[k] : 32'h0;
    endfunction

    // Expectations for the transaction in flight, filled in by the driver.
    logic        active = 1'b0;
    logic        done_flag = 1'b0;
    int          cyc;
    int          we_cnt;
    int          exp_lat;
    int          exp_we_cnt;
    int          exp_we_cyc;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wdata;
    logic [31:0] exp_adr;
    logic        exp_mis;
    logic [31:0] got_rdata;
    logic [31:0] got_wdata;

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (active) begin
                cyc++;
                check("memAdr", memAdr, exp_adr);
                if (memWE) begin
                    we_cnt++;
                    got_wdata = memwrData;
                    check("memWE_cycle", cyc, exp_we_cyc);
                    check("memwrData", memwrData, exp_wdata);
                end
                if (rsp_valid) begin
                    got_rdata = rsp_rdata;
                    check("latency", cyc, exp_lat);
                    check("rsp_rdata", rsp_rdata, exp_rdata);
                    check("rsp_misaligned", {31'b0, rsp_misaligned}, {31'b0, exp_mis});
                    check("memWE_pulses", we_cnt, exp_we_cnt);
                    active    = 1'b0;
                    done_flag = 1'b1;
                end
            end else begin
                check("idle_rsp_valid", {31'b0, rsp_valid}, 32'd0);
                check("idle_memWE", {31'b0, memWE}, 32'd0);
                check("idle_rsp_rdata", rsp_rdata, 32'd0);
                check("idle_rsp_mis", {31'b0, rsp_misaligned}, 32'd0);
            end
        end
    end

    // One transaction: compute expectations from the model, drive, await response,
    // optionally pin the observed load data / store word to a hand-computed literal.
    task automatic op(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic lit_en, input logic [31:0] lit);
        bit        fault;
        bit [31:0] w, v, mask, nw;
        int        sh;
        fault = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00);
        w  = model_rd(addr);
        sh = (size == 2'b00) ? 8 * int'(addr[1:0]) : (size == 2'b01) ? 16 * int'(addr[1]) : 0;
        v  = w >> sh;
        if (size == 2'b00) begin
            v = v & 32'hff;
            if (!uns && v[7]) v = v | 32'hffffff00;
        end else if (size == 2'b01) begin
            v = v & 32'hffff;
            if (!uns && v[15]) v = v | 32'hffff0000;
        end
        mask = (size == 2'b00) ? (32'hff << sh) : (size == 2'b01) ? (32'hffff << sh) : 32'hffffffff;
        nw   = (w & ~mask) | ((wd << sh) & mask);

        @(posedge clk);
        #1;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        exp_adr    = {addr[31:2], 2'b00};
        exp_mis    = fault;
        exp_rdata  = (fault || we) ? 32'h0 : v;
        exp_wdata  = nw;
        exp_we_cnt = (!fault && we) ? 1 : 0;
        exp_lat    = fault ? 1 : (!we ? 3 : (size == 2'b10 ? 2 : 4));
        exp_we_cyc = exp_lat - 1;
        got_rdata  = 32'hxxxxxxxx;
        got_wdata  = 32'hxxxxxxxx;
        cyc        = 0;
        we_cnt     = 0;
        done_flag  = 1'b0;
        active     = 1'b1;
        for (int i = 0; i < 20 && !done_flag; i++) @(posedge clk);
        if (!done_flag) begin
            check("response_timeout", 32'd0, 32'd1);
            active = 1'b0;
        end
        if (lit_en) begin
            if (we && !fault) check("literal_wdata", got_wdata, lit);
            else check("literal_rdata", got_rdata, lit);
        end
        if (we && !fault) model_mem[{addr[31:2], 2'b00}] = nw;
    endtask

    initial begin
        resetn       = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_memAdr", memAdr, 32'd0);
        check("rst_memWE", {31'b0, memWE}, 32'd0);
        check("rst_memwrData", memwrData, 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Preload through the DUT with word stores.
        op(1'b1, 2'b10, 1'b0, 32'h2114, 32'h00ff00ff, 1'b1, 32'h00ff00ff);
        op(1'b1, 2'b10, 1'b0, 32'h208c, 32'hff00ff00, 1'b1, 32'hff00ff00);

        // Loads.
        op(1'b0, 2'b10, 1'b0, 32'h2114, 32'h0, 1'b1, 32'h00ff00ff);
        op(1'b0, 2'b00, 1'b0, 32'h2114, 32'h0, 1'b1, 32'hffffffff);
        op(1'b0, 2'b00, 1'b1, 32'h2114, 32'h0, 1'b1, 32'h000000ff);
        op(1'b0, 2'b01, 1'b0, 32'h208e, 32'h0, 1'b1, 32'hffffff00);
        op(1'b0, 2'b01, 1'b1, 32'h208e, 32'h0, 1'b1, 32'h0000ff00);

        // Byte store read-modify-write, then read back.
        op(1'b1, 2'b00, 1'b0, 32'h208d, 32'h12345678, 1'b1, 32'hff007800);
        op(1'b0, 2'b10, 1'b0, 32'h208c, 32'h0, 1'b1, 32'hff007800);

        // Word store, half store into upper lane, read back.
        op(1'b1, 2'b10, 1'b0, 32'h2114, 32'hdeadbeef, 1'b1, 32'hdeadbeef);
        op(1'b1, 2'b01, 1'b0, 32'h2116, 32'h0000abcd, 1'b1, 32'habcdbeef);
        op(1'b0, 2'b10, 1'b0, 32'h2114, 32'h0, 1'b1, 32'habcdbeef);
        op(1'b0, 2'b00, 1'b0, 32'h2117, 32'h0, 1'b1, 32'hffffffab);
        op(1'b0, 2'b00, 1'b1, 32'h2116, 32'h0, 1'b1, 32'h000000cd);
        op(1'b0, 2'b01, 1'b0, 32'h2114, 32'h0, 1'b1, 32'hffffbeef);

        // Faults: misaligned word load, misaligned half store, illegal size.
        op(1'b0, 2'b10, 1'b0, 32'h2115, 32'h0, 1'b1, 32'h0);
        op(1'b1, 2'b01, 1'b0, 32'h2111, 32'h5555, 1'b1, 32'h0);
        op(1'b1, 2'b11, 1'b0, 32'h2114, 32'h7777, 1'b1, 32'h0);
        check("ram_after_faults", ram[12'h845], 32'habcdbeef);

        // Byte store interrupted by reset during CAP.
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h2114;
        req_wdata = 32'h00000099;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("midrst_memWE", {31'b0, memWE}, 32'd0);
        check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        check("midrst_memAdr", memAdr, 32'd0);
        check("midrst_rsp_rdata", rsp_rdata, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("inrst_memWE", {31'b0, memWE}, 32'd0);
            check("inrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        check("postrst_req_ready", {31'b0, req_ready}, 32'd1);
        repeat (3) @(posedge clk);
        check("ram_after_reset", ram[12'h845], 32'habcdbeef);
        op(1'b0, 2'b10, 1'b0, 32'h2114, 32'h0, 1'b1, 32'habcdbeef);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit between the riscvCpu memory stage and the word-wide, one-cycle-latency data RAM. Accepts one byte/half/word load or store per handshake. Sub-word stores are built as read-modify-write, because the RAM has only a full-word write enable. Sub-word loads are lane-extracted and sign- or zero-extended, and misaligned accesses are rejected without touching memory.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data/word width (fixed 32; 4 byte lanes)
- clk  in  1  single clock; all state updates on posedge
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  LSU idle, request accepted when req_valid&&req_ready at posedge
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: zero-extend (LBU/LHU)
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  load result, valid with rsp_valid, 0 for stores and faults
- rsp_misaligned  out  1  fault flag, valid with rsp_valid
- memAdr  out  ADDR_WIDTH  RAM word address, always {addr_q[31:2],2'b00}
- memwrData  out  DATA_WIDTH  RAM write data
- memWE  out  1  RAM write enable, high only in WR
- memrdData  in  DATA_WIDTH  RAM read data, registered by RAM one edge after memAdr

## Operation
- On accept, latch addr_q, wdata_q, we_q, size_q, uns_q.
- States: IDLE, RD, CAP, WR, DONE.
- req_ready = (state==IDLE). req_valid is ignored in any other state.
- Fault check at accept:
  - size 11 is a fault.
  - half with addr[0]=1 is a fault.
  - word with addr[1:0]!=0 is a fault.
  - On fault: IDLE->DONE, rsp_misaligned=1, rsp_rdata=0, no RAM access.
- Load (any size): IDLE->RD->CAP->DONE.
  - RD drives memAdr with memWE=0.
  - CAP: memrdData is valid; rdata_q <= extract(memrdData).
- Word store: IDLE->WR->DONE. WR drives memwrData=wdata_q, memWE=1.
- Byte/half store: IDLE->RD->CAP->WR->DONE.
  - CAP: merge_q <= memrdData with the addressed lane(s) replaced.
  - WR writes merge_q.
- Extract:
  - byte lane = addr_q[1:0], half lane = addr_q[1].
  - Sign-extend from bit 7/15 unless uns_q=1. Word loads pass through unchanged.
- Merge:
  - byte replaces bits [8*a+7:8*a] with wdata_q[7:0].
  - half replaces [16*h+15:16*h] with wdata_q[15:0].
  - Other lanes are preserved bit-exact.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE.
- Exactly one memWE pulse per store; zero for loads and faults.

## Timing
- Accept edge = E0.
- Latencies (rsp_valid high in the cycle after the listed edge):
  - fault: E0
  - word store: E1
  - load: E2
  - sub-word store: E3
- Next accept earliest at the edge ending DONE+1 (IDLE cycle). No back-to-back pipelining.
- memAdr changes only on accept. It holds the last address while IDLE.
- memwrData is meaningful only while memWE=1.
- Reset values (async, immediate):
  - state=IDLE
  - req_ready=1
  - rsp_valid=0, rsp_rdata=0, rsp_misaligned=0
  - memAdr=0, memwrData=0, memWE=0
  - all latches 0
- Reset mid-operation: the operation is dropped with no rsp_valid. memWE falls asynchronously, so no partial write lands if reset asserts before the WR edge.
- rsp_rdata/rsp_misaligned are registered and return to 0 after DONE.

## Test plan
- RAM[0x2114]=0x00ff00ff; LW 0x2114 -> rsp_valid at E2, rsp_rdata=0x00ff00ff, memWE never high.
- LB 0x2114 -> 0xffffffff; LBU 0x2114 -> 0x000000ff; with RAM[0x208c]=0xff00ff00: LH 0x208e -> 0xffffff00; LHU 0x208e -> 0x0000ff00.
- SB 0x208d wdata 0x12345678 -> single memWE pulse at E3 edge with memwrData=0xff007800, memAdr=0x208c; following LW 0x208c -> 0xff007800.
- SW 0x2114 wdata 0xdeadbeef -> memWE pulse in the cycle after E0, rsp_valid at E1; then SH 0x2116 wdata 0x0000abcd -> memwrData 0xabcdbeef; LW -> 0xabcdbeef.
- LW 0x2115, SH 0x2111, size=11 at 0x2114 -> each: rsp_valid at E0+1 cycle, rsp_misaligned=1, rsp_rdata=0, memWE never high, RAM unchanged.
- SB 0x2114 accepted, resetn low during CAP for 2 cycles -> no memWE, no rsp_valid, all outputs at reset values, RAM unchanged, req_ready=1; after release a LW 0x2114 completes normally.
